// File: rtl/audioport_pkg.sv
// Shared audioport constants and types used by the I2S output stage.
package audioport_pkg;

  localparam int I2S_SCK_DIV    = 4;
  localparam int I2S_SLOT_WIDTH = 32;
  localparam int I2S_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    I2S_IDLE  = 2'd0,
    I2S_PLAY  = 2'd1,
    I2S_DRAIN = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/i2s_frame_timer.sv
// Phase/slot counters for one I2S frame; sck and ws are registered from the
// next counter values so they line up with the frame cycle index.
module i2s_frame_timer
  import audioport_pkg::*;
#(
  parameter int SCK_DIV    = I2S_SCK_DIV,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic load_o,
  output logic shift_o,
  output logic last_cycle_o,
  output logic sck_o,
  output logic ws_o
);

  localparam int PHASE_W = $clog2(SCK_DIV);
  localparam int SLOT_W  = $clog2(2 * SLOT_WIDTH);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SCK_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(SCK_DIV / 2);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0]  WS_FIRST   = SLOT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0]  WS_LAST    = SLOT_W'(2 * SLOT_WIDTH - 2);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               sck_q, sck_d;
  logic               ws_q, ws_d;

  always_comb begin
    phase_d = '0;
    slot_d  = '0;
    if (run_i) begin
      if (phase_q == PHASE_LAST) begin
        phase_d = '0;
        slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
      end else begin
        phase_d = phase_q + PHASE_W'(1);
        slot_d  = slot_q;
      end
    end
    sck_d = (phase_d >= PHASE_HALF);
    ws_d  = (slot_d >= WS_FIRST) && (slot_d <= WS_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      slot_q  <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      slot_q  <= slot_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
    end
  end

  assign load_o       = (phase_q == '0) && (slot_q == '0);
  assign shift_o      = (phase_q == '0) && (slot_q != '0);
  assign last_cycle_o = (phase_q == PHASE_LAST) && (slot_q == SLOT_LAST);
  assign sck_o        = sck_q;
  assign ws_o         = ws_q;

endmodule

// File: rtl/i2s_unit.sv
// I2S output stage: double-buffers one stereo pair and serialises it into a
// Philips I2S frame, requesting the next pair each time one is loaded.
module i2s_unit
  import audioport_pkg::*;
#(
  parameter int SCK_DIV    = I2S_SCK_DIV,
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  play_in,
  input  logic                  tick_in,
  input  logic [DATA_WIDTH-1:0] audio0_in,
  input  logic [DATA_WIDTH-1:0] audio1_in,
  output logic                  req_out,
  output logic                  sck_out,
  output logic                  ws_out,
  output logic                  sdo_out,
  output logic                  underrun_out,
  output logic                  overrun_out
);

  localparam int FW  = 2 * SLOT_WIDTH;
  localparam int PAD = SLOT_WIDTH - DATA_WIDTH;

  // Upstream handshake: tick_in is an unconditional one-cycle write strobe
  // (no backpressure); req_out pulses once per consumed pair to pace it.
  i2s_state_t              state_q, state_d;
  logic                    full_q, full_d;
  logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [FW-1:0]           shift_q, shift_d;
  logic                    req_q, req_d;
  logic                    under_q, under_d;
  logic                    over_q, over_d;

  logic run, frame_start, shift_en, last_cycle, load, going_idle;
  logic [SLOT_WIDTH-1:0] left_slot, right_slot;

  assign run = (state_q != I2S_IDLE) || play_in;

  i2s_frame_timer #(
    .SCK_DIV   (SCK_DIV),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .load_o      (frame_start),
    .shift_o     (shift_en),
    .last_cycle_o(last_cycle),
    .sck_o       (sck_out),
    .ws_o        (ws_out)
  );

  assign load = frame_start &&
                ((state_q == I2S_PLAY) || ((state_q == I2S_IDLE) && play_in));
  // Stopping at the frame boundary: the frame just finished, so go straight to IDLE.
  assign going_idle = last_cycle && !play_in && (state_q != I2S_IDLE);

  assign left_slot  = SLOT_WIDTH'(buf_q[2*DATA_WIDTH-1:DATA_WIDTH]) << PAD;
  assign right_slot = SLOT_WIDTH'(buf_q[DATA_WIDTH-1:0]) << PAD;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      I2S_IDLE:  if (play_in) state_d = I2S_PLAY;
      I2S_PLAY:  if (!play_in) state_d = last_cycle ? I2S_IDLE : I2S_DRAIN;
      I2S_DRAIN: begin
        if (play_in)         state_d = I2S_PLAY;
        else if (last_cycle) state_d = I2S_IDLE;
      end
      default:   state_d = I2S_IDLE;
    endcase
  end

  always_comb begin
    full_d  = full_q;
    buf_d   = buf_q;
    shift_d = shift_q;
    req_d   = load;
    under_d = load && !full_q;
    over_d  = tick_in && full_q && !load;
    if (load) begin
      shift_d = full_q ? {left_slot, right_slot} : '0;
    end else if (going_idle) begin
      shift_d = '0;
    end else if (shift_en && (state_q != I2S_IDLE)) begin
      shift_d = {shift_q[FW-2:0], 1'b0};
    end
    if (load || going_idle) full_d = 1'b0;
    // A same-cycle tick lands after the load has taken the old pair.
    if (tick_in) begin
      buf_d  = {audio0_in, audio1_in};
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= I2S_IDLE;
      full_q  <= 1'b0;
      buf_q   <= '0;
      shift_q <= '0;
      req_q   <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      shift_q <= shift_d;
      req_q   <= req_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign req_out      = req_q;
  assign underrun_out = under_q;
  assign overrun_out  = over_q;
  assign sdo_out      = shift_q[FW-1];

endmodule

// File: tb/tb_i2s_unit.sv
// Bench for i2s_unit: frame-level reference model plus an I2S deserialiser
// whose captured frames are scored against an expected queue.
module tb_i2s_unit;

  localparam int DW  = 24;
  localparam int SW  = 32;
  localparam int DIV = 4;
  localparam int FL  = 2 * SW * DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          play_in = 1'b0;
  logic          tick_in = 1'b0;
  logic [DW-1:0] audio0_in = '0;
  logic [DW-1:0] audio1_in = '0;
  logic req_out, sck_out, ws_out, sdo_out, underrun_out, overrun_out;

  i2s_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .play_in     (play_in),
    .tick_in     (tick_in),
    .audio0_in   (audio0_in),
    .audio1_in   (audio1_in),
    .req_out     (req_out),
    .sck_out     (sck_out),
    .ws_out      (ws_out),
    .sdo_out     (sdo_out),
    .underrun_out(underrun_out),
    .overrun_out (overrun_out)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_active, m_drain, m_full;
  int            m_k;
  logic [DW-1:0] m_bl, m_br, m_fl, m_fr;
  bit            exp_req, exp_under, exp_over;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [63:0] cap, last_frame;
  int          cap_cnt;
  logic        prev_sck;
  bit          auto_tick = 1'b0;
  int          req_cnt, under_cnt, over_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [DW-1:0] l, input logic [DW-1:0] r, input int s);
    if (s >= 0 && s < DW) return l[DW-1-s];
    if (s >= SW && s < SW + DW) return r[SW+DW-1-s];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_drain = 0; m_full = 0; m_k = 0;
    m_bl = '0; m_br = '0; m_fl = '0; m_fr = '0;
    exp_req = 0; exp_under = 0; exp_over = 0;
    exp_q.delete();
    cap = '0; cap_cnt = 0; prev_sck = 1'b0;
  endtask

  // Advance the model by one clk using the inputs of the current cycle.
  task automatic model_step();
    bit load, old_full;
    old_full  = m_full;
    load      = (m_k == 0) && (m_active ? !m_drain : play_in);
    exp_req   = load;
    exp_under = load && !old_full;
    exp_over  = tick_in && old_full && !load;
    if (load) begin
      m_fl = old_full ? m_bl : '0;
      m_fr = old_full ? m_br : '0;
      exp_q.push_back({m_fl, 8'h00, m_fr, 8'h00});
      m_full = 0;
    end
    if (m_active && m_k == FL - 1 && !play_in) m_full = 0;
    if (tick_in) begin
      m_bl = audio0_in; m_br = audio1_in; m_full = 1;
    end
    if (!m_active) begin
      if (play_in) begin m_active = 1; m_drain = 0; m_k = 1; end
    end else if (m_k == FL - 1) begin
      m_k = 0; m_drain = 0;
      if (!play_in) m_active = 0;
    end else begin
      m_k++;
      m_drain = !play_in;
    end
  endtask

  // driver: one clock with the currently driven inputs, then score outputs
  task automatic run_cycle();
    int slot, ph;
    logic e_sck, e_ws, e_sdo;
    logic [63:0] e_frame;
    if (rst_n) model_step();
    slot  = m_k / DIV;
    ph    = m_k % DIV;
    e_sck = (ph >= DIV / 2);
    e_ws  = (slot >= SW - 1) && (slot <= 2 * SW - 2);
    e_sdo = (m_k == 0) ? 1'b0 : frame_bit(m_fl, m_fr, (ph == 0) ? slot - 1 : slot);
    @(posedge clk);
    #1;
    check("req", req_out, exp_req);
    check("underrun", underrun_out, exp_under);
    check("overrun", overrun_out, exp_over);
    check("sck", sck_out, e_sck);
    check("ws", ws_out, e_ws);
    check("sdo", sdo_out, e_sdo);
    req_cnt   += int'(req_out);
    under_cnt += int'(underrun_out);
    over_cnt  += int'(overrun_out);
    if (!prev_sck && sck_out) begin
      cap = {cap[62:0], sdo_out};
      cap_cnt++;
      if (cap_cnt == 2 * SW) begin
        cap_cnt = 0;
        last_frame = cap;
        e_frame = (exp_q.size() > 0) ? exp_q.pop_front() : ~cap;
        check("frame", cap, e_frame);
      end
    end
    prev_sck = sck_out;
    tick_in = 1'b0;
    if (auto_tick && req_out) begin
      tick_in = 1'b1; audio0_in = 24'($urandom); audio1_in = 24'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic wait_k(input int k, input string tag);
    bit hit;
    hit = (m_k == k);
    for (int i = 0; i < 2 * FL && !hit; i++) begin
      run_cycle();
      hit = (m_k == k);
    end
    check(tag, hit, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got_req;
    model_reset();
    // reset state
    run(4);
    rst_n = 1'b1;
    run(10);

    // start: zero frame first, then the A5A5A5 / 123456 pair
    play_in = 1'b1;
    run(5);
    tick_in = 1'b1; audio0_in = 24'hA5A5A5; audio1_in = 24'h123456;
    run(295);
    tick_in = 1'b1; audio0_in = 24'($urandom); audio1_in = 24'($urandom);
    auto_tick = 1'b1;
    run(220);
    check("frame2_literal", last_frame, 64'hA5A5A500_12345600);

    // sustained play, one tick right after every request
    under_cnt = 0; over_cnt = 0;
    run(10 * FL);
    check("sustain_underruns", under_cnt, 0);
    check("sustain_overruns", over_cnt, 0);

    // overrun: second tick overwrites the first before the load
    auto_tick = 1'b0;
    got_req = 1'b0;
    for (int i = 0; i < 2 * FL && !got_req; i++) begin
      run_cycle();
      got_req = req_out;
    end
    check("req_wait", got_req, 1'b1);
    run(10);
    over_cnt = 0;
    tick_in = 1'b1; audio0_in = 24'h000001; audio1_in = 24'($urandom);
    run(20);
    tick_in = 1'b1; audio0_in = 24'h7FFFFF; audio1_in = 24'($urandom);
    run(500);
    check("overrun_pulses", over_cnt, 1);
    check("overrun_left", last_frame[63:40], 24'h7FFFFF);

    // stop at slot 10: frame completes, then silence and no requests
    wait_k(40, "sync_stop");
    play_in = 1'b0;
    run(FL);
    req_cnt = 0;
    run(50);
    check("stopped_reqs", req_cnt, 0);
    play_in = 1'b1;
    run(300);

    // drop and restore play inside one frame
    wait_k(40, "sync_resume");
    play_in = 1'b0;
    run(20);
    play_in = 1'b1;
    req_cnt = 0;
    run(FL);
    check("resume_reqs", req_cnt, 1);

    // randomized play/tick traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) play_in = ~play_in;
      if ($urandom_range(0, 149) == 0) begin
        tick_in = 1'b1; audio0_in = 24'($urandom); audio1_in = 24'($urandom);
      end
      run_cycle();
    end

    // asynchronous reset mid-frame
    play_in = 1'b1;
    wait_k(100, "sync_reset");
    #3 rst_n = 1'b0;
    #1;
    check("rst_req", req_out, 1'b0);
    check("rst_sck", sck_out, 1'b0);
    check("rst_ws", ws_out, 1'b0);
    check("rst_sdo", sdo_out, 1'b0);
    check("rst_under", underrun_out, 1'b0);
    check("rst_over", overrun_out, 1'b0);
    model_reset();
    tick_in = 1'b0;
    play_in = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(20);
    play_in = 1'b1;
    tick_in = 1'b1; audio0_in = 24'($urandom); audio1_in = 24'($urandom);
    run(FL + 300);

    play_in = 1'b0;
    run(FL + 10);
    check("frames_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
